// File: rtl/mem_region_router.sv
//==============================================================================
// Module   : mem_region_router
// Brief    : Registered address-region router for one CPU request at a time.
//            Define MEM_ROUTER_TIMEOUT_EN to bound the slave ack wait.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_region_router #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int NUM_REGIONS  = 4,
    parameter int REGION_SHIFT = 16,
    parameter int TIMEOUT      = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m_valid,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic                          m_we,
    input  logic [DATA_W-1:0]             m_wdata,
    output logic                          m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_err,
    output logic [NUM_REGIONS-1:0]        s_sel,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_we,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
    input  logic [NUM_REGIONS-1:0]        s_ack
);

    localparam int IDX_W = ADDR_W - REGION_SHIFT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       req_idx;
    logic [NUM_REGIONS-1:0] req_sel;
    logic                   req_mapped;
    logic                   ack_hit;
    logic                   tmo_expire;
    logic [DATA_W-1:0]      sel_rdata;

    assign req_idx = m_addr[ADDR_W-1:REGION_SHIFT];

    // Index compare is done wide so out-of-range upper bits never alias a region.
    always_comb begin
        req_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            req_sel[i] = (64'(req_idx) == 64'(i));
        end
    end

    assign req_mapped = |req_sel;

    // s_sel is one-hot while waiting, so an AND-OR mux picks the live slice.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (s_sel[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ack_hit = |(s_ack & s_sel);

`ifdef MEM_ROUTER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [TMO_W-1:0] tmo_cnt;
    // Pre-increment compare: expiry fires in the TIMEOUT-th unacked cycle.
    assign tmo_expire = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            s_sel   <= '0;
            s_addr  <= '0;
            s_we    <= 1'b0;
            s_wdata <= '0;
`ifdef MEM_ROUTER_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_we    <= m_we;
                        s_wdata <= m_wdata;
`ifdef MEM_ROUTER_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (req_mapped) begin
                            s_sel <= req_sel;
                            state <= ST_ACCESS;
                        end else begin
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                            m_ready <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ack_hit) begin
                        m_rdata <= sel_rdata;
                        s_sel   <= '0;
                        m_ready <= 1'b1;
                        state   <= ST_RESP;
                    end else if (tmo_expire) begin
                        s_sel   <= '0;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                        m_ready <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
`ifdef MEM_ROUTER_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_region_router.sv
//==============================================================================
// Module   : tb_mem_region_router
// Brief    : Self-checking bench for mem_region_router with a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_region_router;

    localparam int NR  = 4;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            m_valid;
    logic [31:0]     m_addr;
    logic            m_we;
    logic [31:0]     m_wdata;
    logic            m_ready;
    logic [31:0]     m_rdata;
    logic            m_err;
    logic [NR-1:0]   s_sel;
    logic [31:0]     s_addr;
    logic            s_we;
    logic [31:0]     s_wdata;
    logic [NR*32-1:0] s_rdata;
    logic [NR-1:0]   s_ack;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_region_router #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGIONS(NR), .REGION_SHIFT(16), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    // Observations of one transaction
    int          o_lat, o_selc;
    logic [31:0] o_rd, o_rd_after;
    logic        o_err, o_rdy_after, o_err_after, o_latched_ok, o_hot_bad;
    logic [NR-1:0] o_sel;

    // Expected results from the model
    int          e_lat, e_selc;
    logic [NR-1:0] e_sel;
    logic        e_err;
    logic [31:0] e_rd;

    // Acting as master and slaves: issue one request, ack after 'delay' selected
    // cycles (negative = never), drive 'noise' acks on unselected slaves.
    task automatic run_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rval, input logic [NR-1:0] noise,
                           input int budget);
        bit done = 0;
        m_valid = 1'b1; m_addr = addr; m_we = we; m_wdata = wdata; s_ack = '0;
        o_lat = -1; o_selc = 0; o_sel = '0; o_rd = '0; o_err = 1'b0;
        o_latched_ok = 1'b1; o_hot_bad = 1'b0;
        o_rdy_after = 1'b0; o_err_after = 1'b0; o_rd_after = '0;
        for (int c = 1; c <= budget && !done; c++) begin
            @(posedge clk); #1;
            if ($countones(s_sel) > 1) o_hot_bad = 1'b1;
            if (s_sel != '0) begin
                o_selc++;
                o_sel = o_sel | s_sel;
                if (s_addr !== addr || s_we !== we || s_wdata !== wdata) o_latched_ok = 1'b0;
            end
            if (m_ready === 1'b1) begin
                o_lat = c; o_rd = m_rdata; o_err = m_err; done = 1;
            end else begin
                m_addr  = $urandom; m_we = 1'($urandom); m_wdata = $urandom;
                s_rdata = {$urandom, $urandom, $urandom, $urandom};
                s_ack   = noise & ~s_sel;
                if (s_sel != '0 && o_selc == delay + 1) begin
                    for (int i = 0; i < NR; i++)
                        if (s_sel[i]) s_rdata[i*32 +: 32] = rval;
                    s_ack = s_sel;
                end
            end
        end
        m_valid = 1'b0; s_ack = '0;
        if (done) begin
            @(posedge clk); #1;
            o_rdy_after = m_ready; o_err_after = m_err; o_rd_after = m_rdata;
        end
    endtask

    // Reference model: outcome of a request from the address map and ack timing.
    task automatic model(input logic [31:0] addr, input int delay, input logic [31:0] rval,
                         input int budget);
        int unsigned idx = addr >> 16;
        if (idx >= NR) begin
            e_lat = 1; e_selc = 0; e_sel = '0; e_err = 1'b1; e_rd = '0;
        end else begin
            e_sel = NR'(1) << idx;
            if (delay >= 0 && delay < budget - 1
`ifdef MEM_ROUTER_TIMEOUT_EN
                && delay < TMO
`endif
               ) begin
                e_lat = delay + 2; e_selc = delay + 1; e_err = 1'b0; e_rd = rval;
            end else begin
`ifdef MEM_ROUTER_TIMEOUT_EN
                e_lat = TMO + 1; e_selc = TMO; e_err = 1'b1; e_rd = '0;
`else
                e_lat = -1; e_selc = budget; e_err = 1'b0; e_rd = '0;
`endif
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
        s_rdata = '0; s_ack = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({m_ready, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b err=%b rdata=%h sel=%b addr=%h we=%b wdata=%h, want all 0",
                     m_ready, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        run_req(32'h0001_0040, 1'b0, 32'h0, 0, 32'hCAFE_F00D, '0, 50);
        tests++; if (o_lat !== 2) begin fails++; $display("FAIL read_latency: got %0d want 2", o_lat); end
        tests++; if (o_sel !== 4'b0010 || o_selc !== 1) begin fails++;
            $display("FAIL read_sel: got %b x%0d want 0010 x1", o_sel, o_selc); end
        tests++; if (o_rd !== 32'hCAFE_F00D || o_err !== 1'b0) begin fails++;
            $display("FAIL read_data: got %h err=%b want cafef00d err=0", o_rd, o_err); end
        tests++; if (o_rdy_after !== 1'b0 || o_err_after !== 1'b0) begin fails++;
            $display("FAIL read_ready_pulse: next-cycle ready=%b err=%b want 0 0", o_rdy_after, o_err_after); end
    endtask

    task automatic test_write();
        run_req(32'h0003_0004, 1'b1, 32'h1234_5678, 3, 32'hA5A5_0F0F, '0, 50);
        tests++; if (o_lat !== 5) begin fails++; $display("FAIL write_latency: got %0d want 5", o_lat); end
        tests++; if (o_sel !== 4'b1000 || o_selc !== 4) begin fails++;
            $display("FAIL write_sel: got %b x%0d want 1000 x4", o_sel, o_selc); end
        tests++; if (o_latched_ok !== 1'b1) begin fails++;
            $display("FAIL write_latched: got ok=%b want 1 (s_we/s_wdata/s_addr held)", o_latched_ok); end
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL write_err: got %b want 0", o_err); end
    endtask

    task automatic test_unmapped();
        run_req(32'h0007_0000, 1'b0, 32'h0, 0, 32'h0, '0, 50);
        tests++; if (o_lat !== 1) begin fails++; $display("FAIL unmapped_latency: got %0d want 1", o_lat); end
        tests++; if (o_sel !== '0) begin fails++; $display("FAIL unmapped_sel: got %b want 0000", o_sel); end
        tests++; if (o_err !== 1'b1 || o_rd !== '0) begin fails++;
            $display("FAIL unmapped_resp: got err=%b rdata=%h want err=1 rdata=0", o_err, o_rd); end
        tests++; if (o_err_after !== 1'b0 || o_rdy_after !== 1'b0) begin fails++;
            $display("FAIL unmapped_clear: got err=%b ready=%b want 0 0", o_err_after, o_rdy_after); end
    endtask

    task automatic test_wrong_ack();
        run_req(32'h0002_0010, 1'b0, 32'h0, 4, 32'h600D_BEEF, 4'b0001, 50);
        tests++; if (o_lat !== 6 || o_selc !== 5) begin fails++;
            $display("FAIL wrong_ack_wait: got lat=%0d sel_cycles=%0d want 6 5", o_lat, o_selc); end
        tests++; if (o_rd !== 32'h600D_BEEF || o_err !== 1'b0) begin fails++;
            $display("FAIL wrong_ack_data: got %h err=%b want 600dbeef err=0", o_rd, o_err); end
        tests++; if (o_rd_after !== 32'h600D_BEEF) begin fails++;
            $display("FAIL rdata_hold: got %h want 600dbeef", o_rd_after); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int unsigned idx = $urandom_range(0, 5);
            logic [31:0] addr, wd, rv;
            logic        we;
            int          dly;
            if ($urandom_range(0, 7) == 0) idx = $urandom_range(6, 65535);
            addr = (idx << 16) | ($urandom & 32'hFFFF);
            we = 1'($urandom); wd = $urandom; rv = $urandom; dly = $urandom_range(0, 6);
            run_req(addr, we, wd, dly, rv, NR'($urandom), 50);
            model(addr, dly, rv, 50);
            tests++; if (o_lat !== e_lat) begin fails++;
                $display("FAIL rand_latency[%0d]: addr=%h got %0d want %0d", n, addr, o_lat, e_lat); end
            tests++; if (o_sel !== e_sel || o_selc !== e_selc) begin fails++;
                $display("FAIL rand_sel[%0d]: got %b x%0d want %b x%0d", n, o_sel, o_selc, e_sel, e_selc); end
            tests++; if (o_err !== e_err || o_rd !== e_rd) begin fails++;
                $display("FAIL rand_resp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", n, o_err, o_rd, e_err, e_rd); end
            tests++; if (o_hot_bad !== 1'b0 || o_latched_ok !== 1'b1 || o_rdy_after !== 1'b0) begin fails++;
                $display("FAIL rand_integrity[%0d]: got multihot=%b latched=%b ready_next=%b want 0 1 0",
                         n, o_hot_bad, o_latched_ok, o_rdy_after); end
        end
    endtask

    task automatic test_back_to_back();
        int t0 = cyc;
        logic [31:0] vals [NR];
        int bad = 0;
        for (int r = 0; r < NR; r++) begin
            vals[r] = $urandom;
            run_req(32'(r) << 16, 1'b0, 32'h0, 0, vals[r], '0, 20);
            if (o_rd !== vals[r] || o_lat !== 2) bad++;
        end
        tests++; if (cyc - t0 !== 3 * NR) begin fails++;
            $display("FAIL b2b_cycles: got %0d want %0d", cyc - t0, 3 * NR); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_data: got %0d bad responses want 0", bad); end
    endtask

    task automatic test_timeout();
        // Ack in the last allowed cycle wins over expiry.
        run_req(32'h0000_0100, 1'b0, 32'h0, TMO - 1, 32'h0BAD_CAFE, '0, 120);
        model(32'h0000_0100, TMO - 1, 32'h0BAD_CAFE, 120);
        tests++; if (o_lat !== e_lat || o_err !== e_err || o_rd !== e_rd) begin fails++;
            $display("FAIL timeout_edge_ack: got lat=%0d err=%b rdata=%h want %0d %b %h",
                     o_lat, o_err, o_rd, e_lat, e_err, e_rd); end
        run_req(32'h0000_0200, 1'b0, 32'h0, -1, 32'h0, '0, 100);
        model(32'h0000_0200, -1, 32'h0, 100);
        tests++; if (o_lat !== e_lat || o_selc !== e_selc) begin fails++;
            $display("FAIL timeout_wait: got lat=%0d sel_cycles=%0d want %0d %0d", o_lat, o_selc, e_lat, e_selc); end
        tests++; if (o_err !== e_err || o_rd !== e_rd) begin fails++;
            $display("FAIL timeout_resp: got err=%b rdata=%h want err=%b rdata=%h", o_err, o_rd, e_err, e_rd); end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        tests++; if ({m_ready, s_sel, m_err} !== '0) begin fails++;
            $display("FAIL abort_first: got ready=%b sel=%b err=%b want 0", m_ready, s_sel, m_err); end
        m_valid = 1'b1; m_addr = 32'h0001_0000; m_we = 1'b0; s_ack = '0;
        @(posedge clk); #1;
        m_valid = 1'b0;
        tests++; if (s_sel !== 4'b0010) begin fails++; $display("FAIL abort_sel: got %b want 0010", s_sel); end
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        tests++; if ({m_ready, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata} !== '0) begin fails++;
            $display("FAIL abort_reset: got ready=%b err=%b rdata=%h sel=%b addr=%h want all 0",
                     m_ready, m_err, m_rdata, s_sel, s_addr); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (m_ready === 1'b1 || s_sel !== '0) seen++;
        end
        tests++; if (seen !== 0) begin fails++;
            $display("FAIL abort_no_ready: got %0d active cycles want 0", seen); end
        run_req(32'h0003_0000, 1'b0, 32'h0, 0, 32'h7777_1111, '0, 20);
        tests++; if (o_lat !== 2 || o_rd !== 32'h7777_1111) begin fails++;
            $display("FAIL abort_recover: got lat=%0d rdata=%h want 2 77771111", o_lat, o_rd); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_wrong_ack();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
